scan_chain_driver: RTL and testbench

// Host-side master for the daisy-chained scan_wrapper_lesson_* designs.
// - Generates scan clock, scan data, scan_select and latch_enable for the chain.
// - Captures the chain's serial data_out.
// - Per transaction: shifts an input byte into one selected design slot and latches it.

---
 rtl/scan_chain_driver.sv | 137 +++++++++++++
 tb/tb_scan_chain_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_driver.sv
// Host-side master for a daisy chain of scan-wrapped designs: shifts one byte into a
// selected slot, latches it, captures every slot's outputs and shifts the selected one back.
module scan_chain_driver #(
  parameter int NUM_IOS     = 8,
  parameter int NUM_DESIGNS = 4,
  parameter int CLK_DIV     = 2,
  localparam int SEL_W      = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               start,
  input  logic [SEL_W-1:0]   design_sel,
  input  logic [NUM_IOS-1:0] in_data,
  output logic               busy,
  output logic               done,
  output logic [NUM_IOS-1:0] out_data,
  output logic               scan_clk,
  output logic               scan_data,
  output logic               scan_select,
  output logic               latch_enable,
  input  logic               scan_data_in
);

  localparam int TOTAL  = NUM_IOS * NUM_DESIGNS;
  localparam int PERIOD = 2 * CLK_DIV;
  localparam int PH_W   = $clog2(PERIOD);
  localparam int PC_W   = $clog2(TOTAL + 1);
  localparam int K_W    = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT, DONE} state_t;

  state_t             state, state_nxt;
  logic [PH_W-1:0]    ph;
  logic [PC_W-1:0]    pcnt;
  logic [SEL_W-1:0]   d_cnt, sel_q;
  logic [K_W-1:0]     k_cnt;
  logic [NUM_IOS-1:0] din_q, cap;
  logic               ph_last, per_last, in_slot, hi_phase;

  assign ph_last  = (ph == PH_W'(PERIOD - 1));
  assign per_last = ph_last && (pcnt == PC_W'(TOTAL - 1));
  assign hi_phase = (ph >= PH_W'(CLK_DIV));
  // (d_cnt, k_cnt) track the chain position of the current period; an out-of-range
  // design_sel never matches, which gives the all-zero shift-in and zero result.
  assign in_slot  = (d_cnt == sel_q);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    done         = 1'b0;
    scan_clk     = 1'b0;
    scan_data    = 1'b0;
    scan_select  = 1'b0;
    latch_enable = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = SHIFT_IN;
      SHIFT_IN: begin
        busy      = 1'b1;
        scan_clk  = hi_phase;
        scan_data = in_slot & din_q[k_cnt];
        if (per_last) state_nxt = LATCH;
      end
      LATCH: begin
        busy         = 1'b1;
        latch_enable = 1'b1;
        if (ph_last) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy        = 1'b1;
        scan_clk    = hi_phase;
        scan_select = 1'b1;
        if (ph_last) state_nxt = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        busy     = 1'b1;
        scan_clk = hi_phase;
        if (per_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      ph       <= '0;
      pcnt     <= '0;
      d_cnt    <= '0;
      k_cnt    <= '0;
      sel_q    <= '0;
      din_q    <= '0;
      cap      <= '0;
      out_data <= '0;
    end else begin
      if (state == IDLE || state == DONE) ph <= '0;
      else                                ph <= ph_last ? '0 : ph + PH_W'(1);

      if (state == IDLE) begin
        pcnt  <= '0;
        d_cnt <= SEL_W'(NUM_DESIGNS - 1);
        k_cnt <= K_W'(NUM_IOS - 1);
        if (start) begin
          sel_q <= design_sel;
          din_q <= in_data;
          cap   <= '0;
        end
      end

      // Both shift phases walk positions TOTAL-1 down to 0; the wrap leaves the
      // position counters ready for the next shift phase.
      if ((state == SHIFT_IN || state == SHIFT_OUT) && ph_last) begin
        pcnt <= per_last ? '0 : pcnt + PC_W'(1);
        if (k_cnt == '0) begin
          k_cnt <= K_W'(NUM_IOS - 1);
          d_cnt <= (d_cnt == '0) ? SEL_W'(NUM_DESIGNS - 1) : d_cnt - SEL_W'(1);
        end else begin
          k_cnt <= k_cnt - K_W'(1);
        end
      end

      // Sample on the last low cycle, just before the chain shifts.
      if (state == SHIFT_OUT && ph == PH_W'(CLK_DIV - 1) && in_slot)
        cap[k_cnt] <= scan_data_in;

      if (state == SHIFT_OUT && per_last) out_data <= cap;
    end
  end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: two instances (default chain, and 1-design CLK_DIV=1)
// driving behavioural copy-through chains, checked every cycle against a timeline model.
module tb_scan_chain_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a [2];
  logic [1:0] sel_a   [2];
  logic [7:0] din_a   [2];
  logic       busy_a[2], done_a[2], sc_a[2], sd_a[2], ss_a[2], le_a[2], sdi_a[2];
  logic [7:0] od_a    [2];

  bit [3:0][7:0] dsn0;
  bit [31:0]     ch0;
  bit [7:0]      dsn1, ch1;

  assign sdi_a[0] = ch0[31];
  assign sdi_a[1] = ch1[7];

  scan_chain_driver dut0 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start_a[0]), .design_sel(sel_a[0]),
    .in_data(din_a[0]), .busy(busy_a[0]), .done(done_a[0]), .out_data(od_a[0]),
    .scan_clk(sc_a[0]), .scan_data(sd_a[0]), .scan_select(ss_a[0]),
    .latch_enable(le_a[0]), .scan_data_in(sdi_a[0]));

  scan_chain_driver #(.NUM_IOS(8), .NUM_DESIGNS(1), .CLK_DIV(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start_a[1]), .design_sel(sel_a[1][0]),
    .in_data(din_a[1]), .busy(busy_a[1]), .done(done_a[1]), .out_data(od_a[1]),
    .scan_clk(sc_a[1]), .scan_data(sd_a[1]), .scan_select(ss_a[1]),
    .latch_enable(le_a[1]), .scan_data_in(sdi_a[1]));

  // Chains: shift (or capture) on scan_clk rise; designs copy latched inputs to outputs.
  always @(posedge sc_a[0]) ch0 <= ss_a[0] ? 32'(dsn0) : {ch0[30:0], sd_a[0]};
  always @(posedge sc_a[1]) ch1 <= ss_a[1] ? dsn1 : {ch1[6:0], sd_a[1]};
  always @(posedge clk) if (le_a[0]) dsn0 <= ch0;
  always @(posedge clk) if (le_a[1]) dsn1 <= ch1;

  int cyc = 0;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int nd [2] = '{4, 1};
  int cd [2] = '{2, 1};
  bit         act  [2];
  int         t0   [2];
  int         m_sel[2];
  logic [7:0] m_in [2];
  logic [7:0] m_out[2] = '{8'h00, 8'h00};

  function automatic int lat_of(input int u);
    return 1 + (2 * 8 * nd[u] + 2) * 2 * cd[u];
  endfunction

  function automatic logic [7:0] res(input int u);
    return (m_sel[u] < nd[u]) ? m_in[u] : 8'h00;
  endfunction

  // Expected {busy, done, scan_clk, scan_data, scan_select, latch_enable} at cycle t after accept.
  function automatic logic [5:0] exp_sig(input bit a, input int t, input int s,
                                         input logic [7:0] d, input int ndz, input int cdz);
    int tot, p, l, i, ph, pos;
    logic b, dn, sc, sdv, ss, le;
    tot = 8 * ndz; p = 2 * cdz; l = 1 + (2 * tot + 2) * p;
    {b, dn, sc, sdv, ss, le} = 6'b0;
    if (a && t >= 1 && t < l) begin
      b = 1'b1; i = (t - 1) / p; ph = (t - 1) % p;
      if (i == tot) le = 1'b1;
      else begin
        sc = (ph >= cdz);
        if (i == tot + 1) ss = 1'b1;
        else if (i < tot) begin
          pos = tot - 1 - i;
          sdv = (pos / 8 == s) ? d[pos % 8] : 1'b0;
        end
      end
    end
    dn = a && (t == l);
    return {b, dn, sc, sdv, ss, le};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        act[u]   <= 1'b0;
        m_out[u] <= 8'h00;
      end else if (!act[u]) begin
        if (start_a[u]) begin
          act[u] <= 1'b1; t0[u] <= cyc; m_sel[u] <= int'(sel_a[u]); m_in[u] <= din_a[u];
        end
      end else if (cyc - t0[u] == lat_of(u)) begin
        act[u]   <= 1'b0;
        m_out[u] <= res(u);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("u%0d signals cyc %0d", u, cyc),
            {busy_a[u], done_a[u], sc_a[u], sd_a[u], ss_a[u], le_a[u]},
            exp_sig(act[u], cyc - t0[u], m_sel[u], m_in[u], nd[u], cd[u]));
        chk($sformatf("u%0d out_data cyc %0d", u, cyc), od_a[u],
            (act[u] && (cyc - t0[u] == lat_of(u))) ? res(u) : m_out[u]);
      end
    end
  end

  task automatic txn(input int u, input int s, input logic [7:0] d, input int poke,
                     output int lat, output int fsd, output int acc);
    @(negedge clk);
    start_a[u] = 1'b1; sel_a[u] = 2'(s); din_a[u] = d;
    @(negedge clk);
    start_a[u] = 1'b0; acc = cyc - 1; lat = -1; fsd = -1;
    for (int i = 0; i < 2000; i++) begin
      if (sd_a[u] && fsd < 0) fsd = cyc - acc;
      if (done_a[u]) begin lat = cyc - acc; break; end
      if (i == poke) begin start_a[u] = 1'b1; sel_a[u] = 2'd1; din_a[u] = 8'hFF; end
      else start_a[u] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, fsd, acc, done_prev, n;
    start_a = '{1'b0, 1'b0}; sel_a = '{2'd0, 2'd0}; din_a = '{8'h00, 8'h00};
    start_a[0] = 1'b1;
    @(negedge clk); chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset outputs", {busy_a[0], done_a[0], sc_a[0], sd_a[0], ss_a[0], le_a[0], od_a[0]}, 0);
    start_a[0] = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle after reset", busy_a[0], 0);

    txn(0, 2, 8'hA5, -1, lat, fsd, acc);
    chk("sel2 latency", lat, 265);
    chk("sel2 out_data", od_a[0], 8'hA5);
    chk("sel2 design inputs", 32'(dsn0), 32'h00A5_0000);

    txn(0, 0, 8'h01, -1, lat, fsd, acc);
    chk("sel0 first one-bit cycle", fsd, 125);
    chk("sel0 out_data", od_a[0], 8'h01);
    chk("sel0 design inputs", 32'(dsn0), 32'h0000_0001);

    txn(0, 3, 8'h5A, 50, lat, fsd, acc);
    chk("ignored start latency", lat, 265);
    chk("ignored start out_data", od_a[0], 8'h5A);
    chk("ignored start design inputs", 32'(dsn0), 32'h5A00_0000);
    done_prev = cyc;
    txn(0, 1, 8'hC3, -1, lat, fsd, acc);
    chk("back-to-back accept gap", acc - done_prev, 1);
    chk("back-to-back latency", lat, 265);
    chk("back-to-back out_data", od_a[0], 8'hC3);

    @(negedge clk);
    start_a[0] = 1'b1; sel_a[0] = 2'd2; din_a[0] = 8'h77;
    @(negedge clk);
    start_a[0] = 1'b0; acc = cyc - 1;
    while (cyc < acc + 100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid reset outputs", {busy_a[0], done_a[0], sc_a[0], sd_a[0], ss_a[0], le_a[0], od_a[0]}, 0);
    n = 0;
    repeat (300) begin @(negedge clk); if (done_a[0]) n++; end
    chk("no done after abort", n, 0);
    txn(0, 1, 8'h3C, -1, lat, fsd, acc);
    chk("after abort latency", lat, 265);
    chk("after abort out_data", od_a[0], 8'h3C);
    chk("after abort design inputs", 32'(dsn0), 32'h0000_3C00);

    txn(1, 0, 8'h3C, -1, lat, fsd, acc);
    chk("small latency", lat, 37);
    chk("small out_data", od_a[1], 8'h3C);
    txn(1, 1, 8'h99, -1, lat, fsd, acc);
    chk("small out-of-range latency", lat, 37);
    chk("small out-of-range out_data", od_a[1], 8'h00);
    chk("small out-of-range design inputs", dsn1, 8'h00);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
